// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux: steps the select lines over four
// channels, waits SETTLE cycles per channel, samples each one and presents a 4-bit word.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       d,
    output logic       s0,
    output logic       s1,
    output logic [3:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t      state_r, state_s;
    logic [1:0]  ch_r, ch_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [3:0]  cap_r, cap_s;
    logic [3:0]  word_r, word_s;
    logic        valid_r, valid_s;
    logic        busy_r, busy_s;

    // State and datapath registers; reset discards any partial capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ch_r    <= 2'd0;
            cnt_r   <= 4'd0;
            cap_r   <= 4'd0;
            word_r  <= 4'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ch_r    <= ch_s;
            cnt_r   <= cnt_s;
            cap_r   <= cap_s;
            word_r  <= word_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
        end
    end

    // Next-state and next-register computation for the scan sequence.
    always_comb begin
        state_s = state_r;
        ch_s    = ch_r;
        cnt_s   = cnt_r;
        cap_s   = cap_r;
        word_s  = word_r;
        valid_s = valid_r;
        case (state_r)
            ST_IDLE: begin
                ch_s = 2'd0;
                if (start) begin
                    cnt_s   = RELOAD;
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_SAMPLE: begin
                cap_s[ch_r] = d;
                // The last channel's bit is folded in directly so word is complete on HOLD entry.
                if (ch_r == 2'd3) begin
                    word_s  = {d, cap_r[2:0]};
                    valid_s = 1'b1;
                    state_s = ST_HOLD;
                end else begin
                    ch_s    = ch_r + 2'd1;
                    cnt_s   = RELOAD;
                    state_s = ST_SETTLE;
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    valid_s = 1'b0;
                    ch_s    = 2'd0;
                    if (continuous) begin
                        cnt_s   = RELOAD;
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ch_s    = 2'd0;
                cnt_s   = 4'd0;
                valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    assign s0         = ch_r[1];
    assign s1         = ch_r[0];
    assign word       = word_r;
    assign word_valid = valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed testbench for mux_scan_ctrl at SETTLE=2 with a behavioural 4:1 mux on d.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       word_ready = 1'b0;
    logic       s0, s1, word_valid, busy;
    logic [3:0] word;
    logic [3:0] mux_in = 4'b0000;
    logic       use_force = 1'b0;
    logic       d_force = 1'b0;
    logic       d;
    int         checks = 0;
    int         failures = 0;

    assign d = use_force ? d_force : mux_in[{s0, s1}];

    mux_scan_ctrl #(.SETTLE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .d          (d),
        .s0         (s0),
        .s1         (s1),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({s0, s1, busy, word_valid, word} !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", {s0, s1, busy, word_valid, word}, 8'h00);
        end
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({s0, s1, busy, word_valid, word} !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", {s0, s1, busy, word_valid, word}, 8'h00);
        end
    endtask

    task automatic test_basic_scan();
        logic [1:0] e;
        mux_in = 4'b1010;
        word_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            e = 2'((k - 1) / 3);
            checks++;
            if ({s0, s1, busy, word_valid} !== {e, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL basic_cycle%0d got=%b exp=%b", k, {s0, s1, busy, word_valid}, {e, 1'b1, 1'b0});
            end
            step();
        end
        checks++;
        if ({s0, s1, busy, word_valid, word} !== {4'b1111, 4'b1010}) begin
            failures++;
            $display("FAIL basic_word got=%b exp=%b", {s0, s1, busy, word_valid, word}, {4'b1111, 4'b1010});
        end
        step();
        checks++;
        if ({s0, s1, busy, word_valid, word} !== {4'b0000, 4'b1010}) begin
            failures++;
            $display("FAIL basic_idle got=%b exp=%b", {s0, s1, busy, word_valid, word}, {4'b0000, 4'b1010});
        end
    endtask

    task automatic test_backpressure();
        mux_in = 4'b1010;
        word_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        checks++;
        if ({s0, s1, busy, word_valid, word} !== {4'b1111, 4'b1010}) begin
            failures++;
            $display("FAIL bp_hold_entry got=%b exp=%b", {s0, s1, busy, word_valid, word}, {4'b1111, 4'b1010});
        end
        mux_in = 4'b0101;
        for (int i = 1; i <= 4; i++) begin
            start = 1'b1;
            step();
            checks++;
            if ({s0, s1, busy, word_valid, word} !== {4'b1111, 4'b1010}) begin
                failures++;
                $display("FAIL bp_stall%0d got=%b exp=%b", i, {s0, s1, busy, word_valid, word}, {4'b1111, 4'b1010});
            end
        end
        start = 1'b0;
        word_ready = 1'b1;
        step();
        checks++;
        if ({s0, s1, busy, word_valid, word} !== {4'b0000, 4'b1010}) begin
            failures++;
            $display("FAIL bp_release got=%b exp=%b", {s0, s1, busy, word_valid, word}, {4'b0000, 4'b1010});
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_start_ignored got=%b exp=%b", busy, 1'b0);
        end
    endtask

    task automatic test_reset_mid_scan();
        mux_in = 4'b1111;
        word_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 7; k++) step();
        checks++;
        if ({s0, s1, busy} !== 3'b101) begin
            failures++;
            $display("FAIL rst_pre_ch2 got=%b exp=%b", {s0, s1, busy}, 3'b101);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s0, s1, busy, word_valid, word} !== 8'h00) begin
            failures++;
            $display("FAIL rst_async got=%b exp=%b", {s0, s1, busy, word_valid, word}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({busy, word_valid} !== 2'b00) begin
                failures++;
                $display("FAIL rst_no_word cyc%0d got=%b exp=%b", k, {busy, word_valid}, 2'b00);
            end
        end
    endtask

    task automatic test_settle_filter();
        use_force = 1'b1;
        word_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            d_force = ((k % 3) == 0) ? 1'b1 : ((k % 2) == 1);
            step();
        end
        checks++;
        if ({word_valid, word} !== 5'b11111) begin
            failures++;
            $display("FAIL settle_filter got=%b exp=%b", {word_valid, word}, 5'b11111);
        end
        step();
        use_force = 1'b0;
    endtask

    task automatic test_continuous();
        mux_in = 4'b1010;
        continuous = 1'b1;
        word_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        checks++;
        if ({word_valid, word} !== 5'b11010) begin
            failures++;
            $display("FAIL cont_word1 got=%b exp=%b", {word_valid, word}, 5'b11010);
        end
        mux_in = 4'b0110;
        step();
        for (int k = 14; k <= 25; k++) begin
            checks++;
            if ({busy, word_valid} !== 2'b10) begin
                failures++;
                $display("FAIL cont_gap cyc%0d got=%b exp=%b", k, {busy, word_valid}, 2'b10);
            end
            step();
        end
        checks++;
        if ({word_valid, word} !== 5'b10110) begin
            failures++;
            $display("FAIL cont_word2 got=%b exp=%b", {word_valid, word}, 5'b10110);
        end
        continuous = 1'b0;
        for (int k = 0; k < 14; k++) step();
        checks++;
        if ({busy, word_valid, word} !== 6'b000110) begin
            failures++;
            $display("FAIL cont_drain got=%b exp=%b", {busy, word_valid, word}, 6'b000110);
        end
    endtask

    task automatic test_continuous_drop();
        mux_in = 4'b0101;
        continuous = 1'b1;
        word_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 5; k++) step();
        checks++;
        if ({s0, s1} !== 2'b01) begin
            failures++;
            $display("FAIL drop_ch1 got=%b exp=%b", {s0, s1}, 2'b01);
        end
        continuous = 1'b0;
        for (int k = 5; k < 13; k++) step();
        checks++;
        if ({word_valid, word} !== 5'b10101) begin
            failures++;
            $display("FAIL drop_word got=%b exp=%b", {word_valid, word}, 5'b10101);
        end
        for (int k = 0; k < 15; k++) begin
            step();
            checks++;
            if ({busy, word_valid} !== 2'b00) begin
                failures++;
                $display("FAIL drop_idle cyc%0d got=%b exp=%b", k, {busy, word_valid}, 2'b00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_reset_mid_scan();
        test_settle_filter();
        test_continuous();
        test_continuous_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the settle cycles per channel before sampling (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request one scan; sampled only in IDLE.
REQ-005 The block SHALL have port continuous, input, 1 bit: rescan automatically after each accepted word.
REQ-006 The block SHALL have port d, input, 1 bit: output of the downstream 4:1 mux being scanned.
REQ-007 The block SHALL have port s0, output, 1 bit: mux select MSB (channel index bit 1).
REQ-008 The block SHALL have port s1, output, 1 bit: mux select LSB (channel index bit 0).
REQ-009 The block SHALL have port word, output, 4 bits: captured channels; bit n holds the value sampled on channel n.
REQ-010 The block SHALL have port word_valid, output, 1 bit: word is available.
REQ-011 The block SHALL have port word_ready, input, 1 bit: consumer accepts word when high with word_valid.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE and HOLD, and SHALL keep a 2-bit channel index ch and a 4-bit settle down-counter.
REQ-014 The block SHALL drive s0 = ch[1] and s1 = ch[0] from registers: ch0 gives s0=0,s1=0; ch1 gives 0,1; ch2 gives 1,0; ch3 gives 1,1.
REQ-015 In IDLE with start=1, the next edge SHALL set ch=0, load the counter with SETTLE-1 and enter SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE cycles; d SHALL be ignored throughout SETTLE.
REQ-017 In SAMPLE, which lasts 1 cycle, d SHALL be stored into internal capture bit ch.
REQ-018 From SAMPLE with ch<3, the block SHALL increment ch, reload the counter and return to SETTLE.
REQ-019 From SAMPLE with ch=3, the block SHALL copy the capture register into word and enter HOLD with word_valid=1.
REQ-020 Latency from the cycle start is sampled high to the first cycle with word_valid=1 SHALL be 4*(SETTLE+1)+1 cycles (13 at SETTLE=2).
REQ-021 In HOLD, word_valid, word, s0 and s1 SHALL remain stable until a cycle with word_ready=1.
REQ-022 On handshake in HOLD, the next edge SHALL clear word_valid and SHALL then go either to SETTLE with ch=0 (continuous=1) or to IDLE with ch=0 (continuous=0).
REQ-023 word SHALL change only on HOLD entry, and word SHALL retain its last value in IDLE.
REQ-024 start SHALL be ignored whenever busy=1.
REQ-025 continuous SHALL be evaluated only at the HOLD handshake; deasserting it mid-scan SHALL finish the current word and then go idle.
REQ-026 In IDLE, ch SHALL be 0, so the mux is parked on i0.

Reset
REQ-027 rst_n low SHALL immediately, independent of clk, force state IDLE, ch=0, s0=0, s1=0, counter=0, capture=0, word=4'b0000, word_valid=0 and busy=0.
REQ-028 Reset asserted mid-scan SHALL discard the partial capture, and no word_valid SHALL follow release of reset.
REQ-029 After rst_n rises, the block SHALL wait in IDLE for start.

Verification
REQ-030 The bench SHALL cover reset: assert rst_n=0 during SETTLE of ch2 -> s0=s1=0, busy=0, word_valid=0, word=0 before the next clk edge.
REQ-031 The bench SHALL cover a basic scan: mux model with inputs i3..i0=4'b1010, SETTLE=2, word_ready=1, start pulse -> selects step ch0,ch1,ch2,ch3 every 3 cycles; word_valid on cycle 13; word=4'b1010; busy falls 1 cycle after handshake.
REQ-032 The bench SHALL cover backpressure: word_ready=0 for 5 cycles in HOLD -> word_valid, word=4'b1010, s0=1 and s1=1 stay constant; a start pulse in HOLD is ignored; the handshake on the 6th cycle returns the block to IDLE.
REQ-033 The bench SHALL cover continuous mode: continuous=1 and word_ready=1 with inputs changed to 4'b0110 after the first word -> word_valid pulses every 13 cycles; the second word is 4'b0110.
REQ-034 The bench SHALL cover settle filtering: toggle d every cycle during SETTLE and hold it at 1 only in SAMPLE cycles -> word=4'b1111.
REQ-035 The bench SHALL cover continuous drop: deassert continuous during the ch1 scan -> the current word completes, followed by IDLE and no further word_valid.
